// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: round-robin pick among NUM_REQ sources, then serialize 64 bits LSB-first and hold an idle gap.
// Latency: grant and first serial bit appear one cycle after the latch edge; message + gap spans 64 + GAP_UI cycles.
// Backpressure: requesters hold req/data until their grant pulse; no new grant while busy or while enable_i is low.
module sb_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int MSG_W   = 64,
    parameter int GAP_UI  = 32
) (
    input  logic                       clk_800MHz,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*MSG_W-1:0]   data_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic                       busy_o,
    output logic                       sb_data_o,
    output logic                       sb_clk_en_o,
    output logic                       done_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [5:0] BIT_LAST = 6'd63;
    localparam logic [5:0] GAP_LAST = 6'(GAP_UI - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [MSG_W-1:0]   shift_reg, shift_nxt;
    logic [5:0]         bit_cnt, bit_nxt;
    logic [5:0]         gap_cnt, gap_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               busy_nxt;
    logic               clk_en_nxt;
    logic               done_nxt;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W:0]     idx;

    // Shift register LSB is a flop output and drains to zero by the end of SEND,
    // so the serial line is quiet outside SEND without any extra gating.
    assign sb_data_o = shift_reg[0];

    // Round-robin search: first pending requester at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_REQ)) begin
                idx = idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_i[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        shift_nxt  = shift_reg;
        bit_nxt    = bit_cnt;
        gap_nxt    = gap_cnt;
        grant_nxt  = '0;
        busy_nxt   = busy_o;
        clk_en_nxt = sb_clk_en_o;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i && found) begin
                    state_nxt      = SEND;
                    ptr_nxt        = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
                    shift_nxt      = data_i[win*MSG_W +: MSG_W];
                    bit_nxt        = '0;
                    grant_nxt[win] = 1'b1;
                    busy_nxt       = 1'b1;
                    clk_en_nxt     = 1'b1;
                end
            end
            SEND: begin
                shift_nxt = shift_reg >> 1;
                if (bit_cnt == BIT_LAST) begin
                    state_nxt  = GAP;
                    bit_nxt    = '0;
                    gap_nxt    = '0;
                    clk_en_nxt = 1'b0;
                    done_nxt   = 1'b1;
                end else begin
                    bit_nxt = bit_cnt + 6'd1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    gap_nxt   = '0;
                    busy_nxt  = 1'b0;
                end else begin
                    gap_nxt = gap_cnt + 6'd1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                busy_nxt   = 1'b0;
                clk_en_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any message in flight.
    always_ff @(posedge clk_800MHz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            grant_o     <= '0;
            busy_o      <= 1'b0;
            sb_clk_en_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            shift_reg   <= shift_nxt;
            bit_cnt     <= bit_nxt;
            gap_cnt     <= gap_nxt;
            grant_o     <= grant_nxt;
            busy_o      <= busy_nxt;
            sb_clk_en_o <= clk_en_nxt;
            done_o      <= done_nxt;
        end
    end

endmodule
